// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC register, combinational instruction memory access,
// and a 2-entry {pc, instruction} buffer feeding decode, with redirect and alignment fault.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk_i,
   input  logic        reset_i,
   output logic [31:0] imem_address_o,
   input  logic [31:0] imem_instruction_i,
   input  logic        redirect_valid_i,
   input  logic [31:0] redirect_target_i,
   input  logic        id_ready_i,
   output logic        id_valid_o,
   output logic [31:0] id_instruction_o,
   output logic [31:0] id_pc_o,
   output logic        misaligned_fault_o,
   output logic [31:0] fetch_count_o
);

   logic [31:0] pc_q, pc_d;
   logic [1:0]  count_q, count_d;
   logic [31:0] headPc_q, headPc_d;
   logic [31:0] headInstr_q, headInstr_d;
   logic [31:0] tailPc_q, tailPc_d;
   logic [31:0] tailInstr_q, tailInstr_d;
   logic        fault_q, fault_d;
   logic [31:0] fetchCount_q, fetchCount_d;
   logic        pop;
   logic        push;

   // The buffer is a two-slot shift structure: the head slot always feeds decode.
   always_comb begin
      pc_d         = pc_q;
      count_d      = count_q;
      headPc_d     = headPc_q;
      headInstr_d  = headInstr_q;
      tailPc_d     = tailPc_q;
      tailInstr_d  = tailInstr_q;
      fault_d      = fault_q;
      fetchCount_d = fetchCount_q;

      pop  = (count_q != 2'd0) && id_ready_i;
      push = !redirect_valid_i && !fault_q && ((count_q != 2'd2) || pop);

      if (redirect_valid_i) begin
         count_d = 2'd0;
         pc_d    = {redirect_target_i[31:2], 2'b00};
         fault_d = |redirect_target_i[1:0];
      end else begin
         if (push) begin
            pc_d         = pc_q + 32'd4;
            fetchCount_d = fetchCount_q + 32'd1;
         end
         case ({push, pop})
            2'b11: begin
               if (count_q == 2'd2) begin
                  headPc_d    = tailPc_q;
                  headInstr_d = tailInstr_q;
                  tailPc_d    = pc_q;
                  tailInstr_d = imem_instruction_i;
               end else begin
                  headPc_d    = pc_q;
                  headInstr_d = imem_instruction_i;
               end
            end
            2'b10: begin
               if (count_q == 2'd0) begin
                  headPc_d    = pc_q;
                  headInstr_d = imem_instruction_i;
               end else begin
                  tailPc_d    = pc_q;
                  tailInstr_d = imem_instruction_i;
               end
               count_d = count_q + 2'd1;
            end
            2'b01: begin
               headPc_d    = tailPc_q;
               headInstr_d = tailInstr_q;
               count_d     = count_q - 2'd1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q         <= RESET_PC;
         count_q      <= 2'd0;
         headPc_q     <= 32'd0;
         headInstr_q  <= 32'd0;
         tailPc_q     <= 32'd0;
         tailInstr_q  <= 32'd0;
         fault_q      <= 1'b0;
         fetchCount_q <= 32'd0;
      end else begin
         pc_q         <= pc_d;
         count_q      <= count_d;
         headPc_q     <= headPc_d;
         headInstr_q  <= headInstr_d;
         tailPc_q     <= tailPc_d;
         tailInstr_q  <= tailInstr_d;
         fault_q      <= fault_d;
         fetchCount_q <= fetchCount_d;
      end
   end

   assign imem_address_o     = pc_q;
   assign id_valid_o         = (count_q != 2'd0);
   assign id_pc_o            = headPc_q;
   assign id_instruction_o   = headInstr_q;
   assign misaligned_fault_o = fault_q;
   assign fetch_count_o      = fetchCount_q;

endmodule
